// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared constants for the vector FP multiplier.
// Status bit positions and rounding-mode encodings.
package fp_mult_pkg;

  localparam int ST_ZERO    = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_UNF     = 2;
  localparam int ST_INEXACT = 3;

  localparam logic RND_RNE   = 1'b0;
  localparam logic RND_TRUNC = 1'b1;

endpackage

// File: rtl/fp_mult_lane.sv
// fp_mult_lane: combinational single-lane FP multiply core.
// Flush-to-zero inputs, no specials, saturating results.
module fp_mult_lane
  import fp_mult_pkg::*;
#(
  parameter  int SIG_WIDTH = 23,
  parameter  int EXP_WIDTH = 8,
  localparam int W = SIG_WIDTH + EXP_WIDTH + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         rnd_mode,
  output logic [W-1:0] z,
  output logic [3:0]   status
);

  localparam int PW = 2 * SIG_WIDTH + 2;
  localparam int EW = EXP_WIDTH + 2;
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'(1 << EXP_WIDTH);
  localparam logic signed [EW-1:0] EZERO = '0;

  logic                  sa, sb, sz;
  logic [EXP_WIDTH-1:0]  ea, eb;
  logic [SIG_WIDTH-1:0]  fa, fb;
  logic [PW-1:0]         prod;
  logic [PW-2:0]         pn;
  logic                  norm, guard, sticky, up;
  logic [SIG_WIDTH:0]    frac_r;
  logic signed [EW-1:0]  e;

  always_comb begin
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    sz     = sa ^ sb;
    prod   = PW'({1'b1, fa}) * PW'({1'b1, fb});
    norm   = prod[PW-1];
    pn     = norm ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    guard  = pn[SIG_WIDTH];
    sticky = |pn[SIG_WIDTH-1:0];
    up     = (rnd_mode == RND_RNE) && guard
             && (sticky || pn[SIG_WIDTH+1]);
    frac_r = {1'b0, pn[PW-2 -: SIG_WIDTH]}
             + (SIG_WIDTH+1)'(up);
    // A carry out of the fraction leaves it all-zero: bump e.
    e = EW'(ea) + EW'(eb) - BIAS + EW'(norm)
        + EW'(frac_r[SIG_WIDTH]);

    z      = '0;
    status = '0;
    if (ea == '0 || eb == '0) begin
      status[ST_ZERO] = 1'b1;
    end else if (e >= EMAX) begin
      z = {sz, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b1}}};
      status[ST_OVF]     = 1'b1;
      status[ST_INEXACT] = 1'b1;
    end else if (e <= EZERO) begin
      status[ST_ZERO]    = 1'b1;
      status[ST_UNF]     = 1'b1;
      status[ST_INEXACT] = 1'b1;
    end else begin
      z = {sz, e[EXP_WIDTH-1:0], frac_r[SIG_WIDTH-1:0]};
      status[ST_INEXACT] = guard | sticky;
    end
  end

endmodule

// File: rtl/fp_mult_vec_pipe.sv
// fp_mult_vec_pipe: LANES-wide FP multiplier with a stallable,
// bubble-collapsing valid/ready pipeline of STAGES registers.
module fp_mult_vec_pipe
  import fp_mult_pkg::*;
#(
  parameter  int SIG_WIDTH = 23,
  parameter  int EXP_WIDTH = 8,
  parameter  int LANES     = 4,
  parameter  int STAGES    = 3,
  localparam int W = SIG_WIDTH + EXP_WIDTH + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  input  logic               rnd_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] z,
  output logic [LANES*4-1:0] status
);

  logic [LANES*W-1:0] lz;
  logic [LANES*4-1:0] ls;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_mult_lane #(
      .SIG_WIDTH(SIG_WIDTH),
      .EXP_WIDTH(EXP_WIDTH)
    ) u_lane (
      .a       (a[i*W +: W]),
      .b       (b[i*W +: W]),
      .rnd_mode(rnd_mode),
      .z       (lz[i*W +: W]),
      .status  (ls[i*4 +: 4])
    );
  end

  logic [STAGES-1:0]  v;
  logic [STAGES-1:0]  ld;
  logic [LANES*W-1:0] zq [STAGES];
  logic [LANES*4-1:0] sq [STAGES];

  // Stage k may load if out_ready or any stage at/after k is empty.
  always_comb begin
    logic chain;
    chain = out_ready;
    ld    = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain = chain || !v[k];
      ld[k] = chain;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        zq[k] <= '0;
        sq[k] <= '0;
      end
    end else begin
      if (ld[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          zq[0] <= lz;
          sq[0] <= ls;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            zq[k] <= zq[k-1];
            sq[k] <= sq[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v[STAGES-1];
  assign z         = zq[STAGES-1];
  assign status    = sq[STAGES-1];

endmodule

// File: tb/tb_fp_mult_vec_pipe.sv
// tb_fp_mult_vec_pipe: directed vectors and a flow-control stream
// for fp_mult_vec_pipe (4 lanes of 32-bit floats, 3 stages).
module tb_fp_mult_vec_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] a, b;
  logic         rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] z;
  logic [15:0]  status;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_mult_vec_pipe #(
    .SIG_WIDTH(23),
    .EXP_WIDTH(8),
    .LANES    (4),
    .STAGES   (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .rnd_mode (rnd_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z        (z),
    .status   (status)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Operand k for the stream: lane i = 1.0 + (4k+i) ulp, times 2.0.
  function automatic logic [127:0] sa_vec(input int k);
    logic [127:0] r;
    for (int i = 0; i < 4; i++)
      r[i*32 +: 32] = 32'h3F80_0000 + 32'(k * 4 + i);
    return r;
  endfunction

  function automatic logic [127:0] sz_vec(input int k);
    logic [127:0] r;
    for (int i = 0; i < 4; i++)
      r[i*32 +: 32] = 32'h4000_0000 + 32'(k * 4 + i);
    return r;
  endfunction

  task automatic run_vec(input string tag,
                         input logic [127:0] va,
                         input logic [127:0] vb,
                         input logic rm,
                         input logic [127:0] ez,
                         input logic [15:0] es);
    int edges;
    out_ready = 1'b1;
    #1;
    chk({tag, "/rdy"}, 128'(in_ready), 128'd1);
    a = va; b = vb; rnd_mode = rm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0; rnd_mode = 1'b0;
    edges = 1;
    while (!out_valid && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "/lat"}, 128'(edges), 128'd3);
    chk({tag, "/z"}, z, ez);
    chk({tag, "/st"}, 128'(status), 128'(es));
  endtask

  task automatic stream(input string tag, input int n,
                        input int base, input bit rand_mode);
    int tx, rx;
    logic [127:0] hold_z;
    tx = 0; rx = 0; hold_z = '0;
    for (int c = 0; c < 600 && rx < n; c++) begin
      if (rand_mode) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = (tx < n) && ($urandom_range(0, 2) != 0);
      end else begin
        out_ready = (c >= 6);
        in_valid  = (tx < n);
      end
      a = sa_vec(base + tx);
      b = {4{32'h4000_0000}};
      rnd_mode = 1'(tx);
      #1;
      if (!rand_mode && c == 3) begin
        chk({tag, "/full"}, 128'(in_ready), 128'd0);
        hold_z = z;
      end
      if (!rand_mode && (c == 4 || c == 5))
        chk({tag, "/hold"}, z, hold_z);
      if (out_valid && out_ready) begin
        chk({tag, "/z"}, z, sz_vec(base + rx));
        chk({tag, "/st"}, 128'(status), 128'd0);
        rx++;
      end
      if (in_valid && in_ready) tx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({tag, "/tx"}, 128'(tx), 128'(n));
    chk({tag, "/rx"}, 128'(rx), 128'(n));
  endtask

  initial begin
    int stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; rnd_mode = 1'b0;
    #2;
    chk("rst/ov", 128'(out_valid), 128'd0);
    chk("rst/z", z, 128'd0);
    chk("rst/st", 128'(status), 128'd0);
    chk("rst/ir", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_vec("basic",
      {32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h3FC0_0000},
      {32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000},
      1'b0,
      {32'h0, 32'h0, 32'h0, 32'h4040_0000}, 16'h1110);

    run_vec("rne",
      {32'h3FC0_0000, 32'hC000_0000, 32'h3F80_0001, 32'h3F80_0001},
      {32'h0000_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0000},
      1'b0,
      {32'h0, 32'hC040_0000, 32'h3F80_0002, 32'h3FC0_0002}, 16'h1088);

    run_vec("trunc",
      {32'h3FC0_0000, 32'hC000_0000, 32'h3F80_0001, 32'h3F80_0001},
      {32'h0000_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0000},
      1'b1,
      {32'h0, 32'hC040_0000, 32'h3F80_0002, 32'h3FC0_0001}, 16'h1088);

    run_vec("sat",
      {32'h3FC0_0000, 32'hFF00_0000, 32'h8080_0000, 32'h7F00_0000},
      {32'h4000_0000, 32'h7F00_0000, 32'h0080_0000, 32'h7F00_0000},
      1'b0,
      {32'h4040_0000, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF}, 16'h0ADA);

    run_vec("edge",
      {32'h7F80_0000, 32'h0080_0000, 32'h0080_0000, 32'h7F7F_FFFF},
      {32'h3F80_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3F80_0001},
      1'b0,
      {32'h7F80_0000, 32'h0, 32'h0080_0000, 32'h7F80_0000}, 16'h0D08);

    @(posedge clk); #1;
    stream("bp", 10, 0, 1'b0);
    stream("rnd", 30, 100, 1'b1);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = sa_vec(500 + i);
      b = {4{32'h4000_0000}};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid/pre", 128'(out_valid), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid/ov", 128'(out_valid), 128'd0);
    chk("mid/z", z, 128'd0);
    chk("mid/st", 128'(status), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid/ir", 128'(in_ready), 128'd1);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("mid/stale", 128'(stale), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_mult_vec_pipe.md
# fp_mult_vec_pipe

Multi-lane floating-point multiplier with valid/ready flow control. It is the successor to the fixed-latency, no-backpressure FP multiply pipe used in the vector engine (RMSnorm scaling, gain multiply). It adds:

- per-lane SIMD operation;
- selectable rounding (round-to-nearest-even or truncate);
- overflow/underflow saturation with status flags;
- a stallable pipeline, so downstream consumers can throttle it without losing data.

## Interface
- SIG_WIDTH, 23, stored fraction bits
- EXP_WIDTH, 8, exponent bits; bias = 2^(EXP_WIDTH-1)-1
- LANES, 4, independent multipliers sharing one handshake
- STAGES, 3, pipeline register stages (>=1); also the latency
- W (derived), SIG_WIDTH+EXP_WIDTH+1, element width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  operand vector valid
- in_ready  out  1  block can accept operands this cycle
- a  in  LANES*W  operand A; lane i occupies bits [i*W +: W]
- b  in  LANES*W  operand B; same lane packing as a
- rnd_mode  in  1  0 = round-to-nearest-even, 1 = truncate; sampled with operands
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts result
- z  out  LANES*W  products, lane-packed like a
- status  out  LANES*4  per lane: [0] zero, [1] overflow, [2] underflow, [3] inexact

## Operation
**Handshake.** A transfer occurs when in_valid && in_ready; the lane results are captured into stage 1.

**Operand decode** (no IEEE special values):
- exp==0 means zero (denormals flushed).
- exp all-ones is an ordinary finite exponent.

**Per-lane arithmetic:**
- sign = sa^sb.
- Product = {1,fa}*{1,fb}, 2*SIG_WIDTH+2 bits.
- Normalise by 1 if the MSB is set.
- e = ea+eb-bias+norm, evaluated at EXP_WIDTH+2 bits signed.
- rnd_mode=0:
  - guard = first dropped bit; sticky = OR of the rest.
  - Round up if guard && (sticky || lsb).
  - A mantissa carry-out renormalises and gives e+1.
  - inexact = guard|sticky.
- rnd_mode=1: drop the bits; inexact is set the same way.

**Result classes**, in this priority order:
- Either operand zero: z=+0 (positive zero, all bits clear); zero=1; other flags 0.
- e >= 2^EXP_WIDTH after rounding: saturate to {sign, all-ones exp, all-ones frac}; overflow=1; inexact=1.
- e <= 0: z=+0; underflow=1; zero=1; inexact=1.
- Otherwise: z={sign, e[EXP_WIDTH-1:0], frac}.

**Lanes** are fully independent; the flags of one lane never affect another.

**Pipeline stages.**
- Each stage holds valid, z and status for every lane, plus nothing else.
- Stage k loads from stage k-1 when stage k is empty or is itself advancing.
- Stage STAGES advances when out_ready.
- The pipeline is bubble-collapsing: an empty stage is filled even while stages further downstream are stalled.

## Timing
- **Reset:** every stage valid=0, z=0, status=0. Therefore out_valid=0, z=0, status=0, and in_ready=1 after reset release.
- **Latency:** exactly STAGES cycles from the accepting edge to out_valid high, with out_ready held 1.
- **Throughput:** one vector per cycle while out_ready=1.
- **in_ready** = ~stage1.valid || stage1 advancing. It is combinational from out_ready through the valid chain; there is no combinational path from in_valid, a or b.
- **Result stability:** while out_valid && !out_ready, z and status hold stable.
- **Full pipeline:** with out_ready held low, up to STAGES vectors are stored and in_ready=0 after that. Accept and output on the same cycle when full is permitted, and ordering is preserved.
- **Reset mid-operation:** all in-flight vectors are discarded immediately (asynchronous); nothing is emitted after release.
- **rnd_mode** applies only to the vector accepted with it.

## Structure
- Package fp_mult_pkg holds:
  - status bit index constants (ST_ZERO=0, ST_OVF=1, ST_UNF=2, ST_INEXACT=3);
  - rounding-mode constants (RND_RNE=0, RND_TRUNC=1).
- Sub-module fp_mult_lane: combinational single-lane core (a, b, rnd_mode -> z, status[3:0]), instantiated LANES times via generate.
- Top level contains only the stage registers and the handshake logic.

## Test plan
- **Basic product:** lane0 0x3FC00000 * 0x40000000, RNE, out_ready=1. Expect 0x40400000, status 0 exactly 3 cycles after accept. Other lanes: 0x80000000 * 0x3F800000 -> 0x00000000, status 0x1.
- **Rounding tie:**
  - 0x3F800001 * 0x3FC00000 with RNE -> 0x3FC00002, inexact=1.
  - Same operands with truncate -> 0x3FC00001, inexact=1.
  - 0x3F800001 * 0x3F800001 with RNE -> 0x3F800002.
- **Saturation:**
  - 0x7F000000 * 0x7F000000 -> 0x7FFFFFFF, status 0xA.
  - 0x00800000 * 0x00800000 -> 0x00000000, status 0xD.
- **Backpressure:** stream 10 vectors with out_ready low for 6 cycles.
  - in_ready falls after 3 accepts.
  - z holds stable while stalled.
  - All 10 results arrive in order, with none dropped or duplicated.
  - Random in_valid/out_ready toggling is checked against a reference model.
- **Reset mid-stream:** assert rst_n low with 3 vectors in flight.
  - out_valid, z and status go to 0 without waiting for a clock.
  - in_ready=1 after release.
  - No stale output appears.
- **Lane independence:** LANES=4 with mixed overflow/zero/normal per lane. Each lane's z and status match its own expected value.
